// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI burst arbiter: controller states and default
// chip-select timing.
package spi_arb_pkg;

  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    NEXT,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/spi_arb_select.sv
// Winner selection for the SPI burst arbiter: request vector -> one-hot winner.
// Fixed lowest-index priority by default; SPI_ARB_ROUND_ROBIN_EN selects round robin.
module spi_arb_select #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef SPI_ARB_ROUND_ROBIN_EN
  input  logic [NUM_REQ-1:0] i_last_gnt,
`endif
  output logic [NUM_REQ-1:0] o_win
);

  function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_upper;

  // Mask keeps only the indices strictly above the last grant; if none of
  // those request, wrap around to the lowest requester overall.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = seen;
      seen      = seen | i_last_gnt[i];
    end
  end

  assign w_upper = i_req & w_mask;
  assign o_win   = (|w_upper) ? lowest_set(w_upper) : lowest_set(i_req);
`else
  assign o_win = lowest_set(i_req);
`endif

endmodule

// File: rtl/spi_burst_arbiter.sv
// Arbitrates byte bursts from NUM_REQ requesters onto one byte-level SPI master,
// with per-requester chip select. Optional macro: SPI_ARB_ROUND_ROBIN_EN.
module spi_burst_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_tx_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rx_data,
  output logic                 spi_start,
  output logic [7:0]           spi_tx_data,
  input  logic                 spi_busy,
  input  logic                 spi_ready,
  input  logic [7:0]           spi_rx_data,
  output logic [NUM_REQ-1:0]   cs_n
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_cs_n;
  logic [NUM_REQ-1:0] r_ack;
  logic [7:0]         r_rx_data;
  logic               r_spi_start;
  logic [7:0]         r_spi_tx_data;
  logic               r_last;

  logic [NUM_REQ-1:0] w_win;
  logic [7:0]         w_tx_byte;
  logic               w_req_sel;
  logic               w_last_sel;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [NUM_REQ-1:0] r_rr_ptr;

  spi_arb_select #(
    .NUM_REQ    (NUM_REQ)
  ) u_select (
    .i_req      (req),
    .i_last_gnt (r_rr_ptr),
    .o_win      (w_win)
  );
`else
  spi_arb_select #(
    .NUM_REQ (NUM_REQ)
  ) u_select (
    .i_req   (req),
    .o_win   (w_win)
  );
`endif

  always_comb begin
    w_tx_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_tx_byte = w_tx_byte | req_tx_data[8*i +: 8];
    end
  end

  assign w_req_sel  = |(req & r_gnt);
  assign w_last_sel = |(req_last & r_gnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_gnt         <= '0;
      r_cs_n        <= '1;
      r_ack         <= '0;
      r_rx_data     <= '0;
      r_spi_start   <= 1'b0;
      r_spi_tx_data <= '0;
      r_last        <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      r_rr_ptr      <= {1'b1, {(NUM_REQ-1){1'b0}}};
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt   <= w_win;
            r_cs_n  <= ~w_win;
            r_cnt   <= '0;
            r_state <= SETUP;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            r_rr_ptr <= w_win;
`endif
          end
        end

        SETUP: begin
          if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
            r_cnt         <= '0;
            r_spi_tx_data <= w_tx_byte;
            r_last        <= w_last_sel;
            r_spi_start   <= !spi_busy;
            r_state       <= START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Start is only raised once the master is idle, and dropped on the
        // first busy cycle it causes.
        START: begin
          if (r_spi_start && spi_busy) begin
            r_spi_start <= 1'b0;
            r_state     <= WAIT;
          end else if (!spi_busy) begin
            r_spi_start <= 1'b1;
          end
        end

        WAIT: begin
          if (!spi_busy && spi_ready) begin
            r_rx_data <= spi_rx_data;
            r_ack     <= r_gnt;
            r_cnt     <= '0;
            r_state   <= r_last ? HOLD : NEXT;
          end
        end

        // The ack cycle is skipped so the requester can present its next byte.
        NEXT: begin
          if (r_ack == '0) begin
            if (w_req_sel) begin
              r_spi_tx_data <= w_tx_byte;
              r_last        <= w_last_sel;
              r_spi_start   <= !spi_busy;
              r_state       <= START;
            end else begin
              r_cnt   <= '0;
              r_state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (r_gnt != '0) begin
            if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
              r_cnt  <= '0;
              r_gnt  <= '0;
              r_cs_n <= '1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign cs_n        = r_cs_n;
  assign ack         = r_ack;
  assign rx_data     = r_rx_data;
  assign spi_start   = r_spi_start;
  assign spi_tx_data = r_spi_tx_data;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter with a simple SPI master model.
// Expected grant order follows SPI_ARB_ROUND_ROBIN_EN when defined.
module tb_spi_burst_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_tx_data;
  logic [1:0]  req_last;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [7:0]  rx_data;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_busy;
  logic        spi_ready;
  logic [7:0]  spi_rx_data;
  logic [1:0]  cs_n;

  int checks   = 0;
  int failures = 0;

  // SPI master model and monitor state
  logic       hold_busy = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         busy_cnt;
  logic [7:0] tx_log[$];
  int         ack_cnt[2];
  int         cs_rise_cnt[2];
  int         start_rise_cnt;
  int         multi_cs_err = 0;
  int         stray_ack_err = 0;
  int         start_busy_err = 0;
  logic       prev_start;
  logic [1:0] prev_cs;

  spi_burst_arbiter #(
    .NUM_REQ  (2),
    .CS_SETUP (2),
    .CS_HOLD  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_tx_data (req_tx_data),
    .req_last    (req_last),
    .gnt         (gnt),
    .ack         (ack),
    .rx_data     (rx_data),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_busy    (spi_busy),
    .spi_ready   (spi_ready),
    .spi_rx_data (spi_rx_data),
    .cs_n        (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    spi_busy    = 1'b0;
    spi_ready   = 1'b1;
    spi_rx_data = 8'h00;
    busy_cnt    = 0;
    prev_start  = 1'b0;
    prev_cs     = 2'b11;
    forever begin
      @(negedge clk);
      if ($countones(~cs_n) > 1) multi_cs_err++;
      if ((ack & ~gnt) != 2'b00) stray_ack_err++;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) ack_cnt[i]++;
        if (!prev_cs[i] && cs_n[i]) cs_rise_cnt[i]++;
      end
      if (spi_start && !prev_start) begin
        start_rise_cnt++;
        if (spi_busy) start_busy_err++;
      end
      prev_start = spi_start;
      prev_cs    = cs_n;
      if (rst) begin
        spi_busy  = 1'b0;
        spi_ready = 1'b1;
        busy_cnt  = 0;
      end else if (spi_busy) begin
        if (!hold_busy) begin
          if (busy_cnt == 0) begin
            spi_busy    = 1'b0;
            spi_ready   = 1'b1;
            spi_rx_data = slave_byte;
          end else begin
            busy_cnt--;
          end
        end
      end else if (spi_start) begin
        spi_busy  = 1'b1;
        spi_ready = 1'b0;
        busy_cnt  = 3;
        tx_log.push_back(spi_tx_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counters;
    ack_cnt        = '{0, 0};
    cs_rise_cnt    = '{0, 0};
    start_rise_cnt = 0;
    tx_log.delete();
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input bit want_grant, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if ((gnt != 2'b00) == want_grant) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [1:0] exp_winner(input int burst);
`ifdef SPI_ARB_ROUND_ROBIN_EN
    return (burst % 2 == 0) ? 2'b01 : 2'b10;
`else
    return (burst >= 0) ? 2'b01 : 2'b10;
`endif
  endfunction

  task automatic test_reset;
    rst = 1'b1; req = 2'b00; req_last = 2'b00; req_tx_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gnt !== 2'b00)         begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (cs_n !== 2'b11)        begin failures++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
    checks++; if (ack !== 2'b00)         begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (spi_start !== 1'b0)    begin failures++; $display("FAIL reset_spi_start got=%b exp=0", spi_start); end
    checks++; if (spi_tx_data !== 8'h00) begin failures++; $display("FAIL reset_spi_tx_data got=%h exp=00", spi_tx_data); end
    checks++; if (rx_data !== 8'h00)     begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte;
    bit ok;
    clear_counters();
    req_tx_data[7:0] = 8'hA5; req_last = 2'b01; slave_byte = 8'h3C; req = 2'b01;
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b01)      begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (cs_n !== 2'b10)     begin failures++; $display("FAIL single_cs_low got=%b exp=10", cs_n); end
    checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL single_start_c0 got=%b exp=0", spi_start); end
    @(posedge clk); #1;
    checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL single_start_c1 got=%b exp=0", spi_start); end
    @(posedge clk); #1;
    checks++; if (spi_start !== 1'b1)    begin failures++; $display("FAIL single_start_c2 got=%b exp=1", spi_start); end
    checks++; if (spi_tx_data !== 8'hA5) begin failures++; $display("FAIL single_tx got=%h exp=a5", spi_tx_data); end
    wait_ack(40, ok);
    checks++; if (ok !== 1'b1)       begin failures++; $display("FAIL single_ack_timeout got=%b exp=1", ok); end
    checks++; if (ack !== 2'b01)     begin failures++; $display("FAIL single_ack got=%b exp=01", ack); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL single_rx got=%h exp=3c", rx_data); end
    req = 2'b00;
    @(posedge clk); #1;
    checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL single_hold_cs got=%b exp=10", cs_n); end
    @(posedge clk); #1;
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL single_cs_release got=%b exp=11", cs_n); end
    checks++; if (gnt !== 2'b00)  begin failures++; $display("FAIL single_gnt_clear got=%b exp=00", gnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ack_cnt[0] !== 1)  begin failures++; $display("FAIL single_ack_count got=%0d exp=1", ack_cnt[0]); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL single_rx_held got=%h exp=3c", rx_data); end
  endtask

  task automatic test_burst;
    bit ok;
    clear_counters();
    req_tx_data[15:8] = 8'h01; req_last = 2'b00; slave_byte = 8'h81; req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      wait_ack(60, ok);
      checks++; if (ok !== 1'b1)            begin failures++; $display("FAIL burst_ack_timeout byte=%0d got=%b exp=1", k, ok); end
      checks++; if (ack !== 2'b10)          begin failures++; $display("FAIL burst_ack byte=%0d got=%b exp=10", k, ack); end
      checks++; if (rx_data !== 8'(8'h81 + k)) begin failures++; $display("FAIL burst_rx byte=%0d got=%h exp=%h", k, rx_data, 8'(8'h81 + k)); end
      checks++; if (cs_n !== 2'b01)         begin failures++; $display("FAIL burst_cs byte=%0d got=%b exp=01", k, cs_n); end
      if (k < 2) begin
        req_tx_data[15:8] = 8'(k + 2);
        req_last          = (k == 1) ? 2'b10 : 2'b00;
        slave_byte        = 8'(8'h82 + k);
      end else begin
        req = 2'b00;
      end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ack_cnt[1] !== 3)     begin failures++; $display("FAIL burst_ack1_count got=%0d exp=3", ack_cnt[1]); end
    checks++; if (ack_cnt[0] !== 0)     begin failures++; $display("FAIL burst_ack0_count got=%0d exp=0", ack_cnt[0]); end
    checks++; if (cs_rise_cnt[1] !== 1) begin failures++; $display("FAIL burst_cs_glitch got=%0d exp=1", cs_rise_cnt[1]); end
    checks++; if (cs_n !== 2'b11)       begin failures++; $display("FAIL burst_cs_end got=%b exp=11", cs_n); end
    checks++; if (tx_log.size() !== 3)  begin failures++; $display("FAIL burst_tx_count got=%0d exp=3", tx_log.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (tx_log[k] !== 8'(k + 1)) begin failures++; $display("FAIL burst_tx byte=%0d got=%h exp=%h", k, tx_log[k], 8'(k + 1)); end
      end
    end
  endtask

  task automatic test_contention;
    bit ok;
    int exp0, exp1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_counters();
    exp0 = 0; exp1 = 0;
    req_tx_data = {8'h20, 8'h10}; req_last = 2'b11; slave_byte = 8'h99; req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      if (exp_winner(b) == 2'b01) exp0++; else exp1++;
      wait_gnt(1'b1, 40, ok);
      checks++; if (ok !== 1'b1)          begin failures++; $display("FAIL contend_gnt_timeout burst=%0d got=%b exp=1", b, ok); end
      checks++; if (gnt !== exp_winner(b)) begin failures++; $display("FAIL contend_gnt burst=%0d got=%b exp=%b", b, gnt, exp_winner(b)); end
      wait_ack(40, ok);
      checks++; if (ack !== exp_winner(b)) begin failures++; $display("FAIL contend_ack burst=%0d got=%b exp=%b", b, ack, exp_winner(b)); end
      wait_gnt(1'b0, 20, ok);
      checks++; if (ok !== 1'b1)          begin failures++; $display("FAIL contend_release_timeout burst=%0d got=%b exp=1", b, ok); end
    end
    req = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ack_cnt[0] !== exp0) begin failures++; $display("FAIL contend_ack0_count got=%0d exp=%0d", ack_cnt[0], exp0); end
    checks++; if (ack_cnt[1] !== exp1) begin failures++; $display("FAIL contend_ack1_count got=%0d exp=%0d", ack_cnt[1], exp1); end
  endtask

  task automatic test_abort;
    bit ok;
    clear_counters();
    req_tx_data[7:0] = 8'h55; req_last = 2'b00; slave_byte = 8'h66; req = 2'b01;
    wait_ack(40, ok);
    checks++; if (ok !== 1'b1)       begin failures++; $display("FAIL abort_ack_timeout got=%b exp=1", ok); end
    checks++; if (rx_data !== 8'h66) begin failures++; $display("FAIL abort_rx got=%h exp=66", rx_data); end
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL abort_hold_cs got=%b exp=10", cs_n); end
    @(posedge clk); #1;
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL abort_cs_release got=%b exp=11", cs_n); end
    checks++; if (gnt !== 2'b00)  begin failures++; $display("FAIL abort_gnt got=%b exp=00", gnt); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (start_rise_cnt !== 1) begin failures++; $display("FAIL abort_start_count got=%0d exp=1", start_rise_cnt); end
    checks++; if (ack_cnt[0] !== 1)      begin failures++; $display("FAIL abort_ack_count got=%0d exp=1", ack_cnt[0]); end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    clear_counters();
    hold_busy = 1'b1;
    req_tx_data[7:0] = 8'h77; req_last = 2'b01; req = 2'b01;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (spi_busy && !spi_start && gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstwait_reach_wait got=%b exp=1", ok); end
    rst = 1'b1;
    #1;
    checks++; if (cs_n !== 2'b11)     begin failures++; $display("FAIL rstwait_cs_n got=%b exp=11", cs_n); end
    checks++; if (gnt !== 2'b00)      begin failures++; $display("FAIL rstwait_gnt got=%b exp=00", gnt); end
    checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL rstwait_start got=%b exp=0", spi_start); end
    checks++; if (ack !== 2'b00)      begin failures++; $display("FAIL rstwait_ack got=%b exp=00", ack); end
    req = 2'b00;
    hold_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_tx_data[15:8] = 8'h42; req_last = 2'b10; slave_byte = 8'h24; req = 2'b10;
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rstwait_early_gnt got=%b exp=00", gnt); end
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b10)  begin failures++; $display("FAIL rstwait_regrant got=%b exp=10", gnt); end
    checks++; if (cs_n !== 2'b01) begin failures++; $display("FAIL rstwait_recs got=%b exp=01", cs_n); end
    wait_ack(40, ok);
    checks++; if (rx_data !== 8'h24) begin failures++; $display("FAIL rstwait_rx got=%h exp=24", rx_data); end
    req = 2'b00;
    wait_gnt(1'b0, 20, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstwait_release_timeout got=%b exp=1", ok); end
  endtask

  task automatic test_invariants;
    checks++; if (multi_cs_err !== 0)   begin failures++; $display("FAIL inv_multi_cs got=%0d exp=0", multi_cs_err); end
    checks++; if (stray_ack_err !== 0)  begin failures++; $display("FAIL inv_stray_ack got=%0d exp=0", stray_ack_err); end
    checks++; if (start_busy_err !== 0) begin failures++; $display("FAIL inv_start_while_busy got=%0d exp=0", start_busy_err); end
  endtask

  initial begin
    clear_counters();
    test_reset();
    test_single_byte();
    test_burst();
    test_contention();
    test_abort();
    test_reset_mid_wait();
    repeat (4) @(posedge clk);
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
